uart_rx_frame_loader: RTL

- Sequences byte traffic from the UART receiver into framed image loads for the MAC datapath.
- Parses the frame format: SYNC, LEN_HI, LEN_LO, payload bytes, CHECKSUM.
- Writes each payload byte into the pixel buffer memory and validates length and checksum.
- Holds a completed frame until the consumer acknowledges it.

---
 rtl/uart_rx_frame_loader_pkg.sv | 28 ++
 rtl/frame_timeout_timer.sv | 40 ++++
 rtl/uart_rx_frame_loader.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_frame_loader_pkg.sv
// Shared frame-loader definitions: FSM state encoding, error codes, default sync marker
// and the header length legality rule.
package uart_rx_frame_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LEN_HI  = 3'd1,
      ST_LEN_LO  = 3'd2,
      ST_PAYLOAD = 3'd3,
      ST_CHECK   = 3'd4,
      ST_HOLD    = 3'd5
   } state_e;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'b00,
      ERR_LEN     = 2'b01,
      ERR_CSUM    = 2'b10,
      ERR_TIMEOUT = 2'b11
   } err_e;

   localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

   // A zero-length frame carries nothing to load, so it is rejected like an oversize one.
   function automatic logic len_legal(input logic [15:0] len, input logic [15:0] max_len);
      return (len != 16'd0) && (len <= max_len);
   endfunction

endpackage

// File: rtl/frame_timeout_timer.sv
// Inter-byte idle timer for the frame loader: reloads on clear, counts down while enabled.
// Assembled only when FRAME_TIMEOUT_EN is defined; otherwise this file is empty.
`ifdef FRAME_TIMEOUT_EN
module frame_timeout_timer #(
   parameter int unsigned CYCLES = 2000000
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam int unsigned CNT_W = (CYCLES > 2) ? $clog2(CYCLES) : 1;
   // Loading CYCLES-1 makes expired_o visible on the CYCLES-th enabled clock after a clear.
   localparam logic [CNT_W-1:0] LOAD = CNT_W'(CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = LOAD;
      end else if (enable_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q <= LOAD;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == '0);

endmodule
`endif

// File: rtl/uart_rx_frame_loader.sv
// Parses SYNC/LEN_HI/LEN_LO/payload/CHECKSUM frames from the UART receiver into the pixel buffer.
// Define FRAME_TIMEOUT_EN to abort frames that stall between bytes for TIMEOUT_CYCLES clocks.
//
// state      | meaning
// IDLE       | hunting for SYNC_BYTE
// LEN_HI     | expecting length high byte
// LEN_LO     | expecting length low byte, length validated here
// PAYLOAD    | writing payload bytes to the buffer
// CHECK      | expecting checksum byte
// HOLD       | good frame held until frame_ack
module uart_rx_frame_loader
   import uart_rx_frame_loader_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 10,
   parameter int unsigned MAX_PAYLOAD    = 784,
   parameter logic [7:0]  SYNC_BYTE      = SYNC_DEFAULT,
   parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic [7:0]            rx_data_i,
   input  logic                  rx_done_tick_i,
   output logic                  wr_en_o,
   output logic [ADDR_WIDTH-1:0] wr_addr_o,
   output logic [7:0]            wr_data_o,
   output logic                  frame_valid_o,
   output logic [15:0]           frame_len_o,
   input  logic                  frame_ack_i,
   output logic                  frame_error_o,
   output logic [1:0]            err_code_o,
   output logic                  overrun_o,
   output logic                  busy_o
);

   localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD);

   state_e                state_q, state_d;
   logic [15:0]           len_q, len_d;
   logic [7:0]            acc_q, acc_d;
   logic [ADDR_WIDTH-1:0] idx_q, idx_d;
   logic                  wr_en_q, wr_en_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]            wr_data_q, wr_data_d;
   logic                  frame_valid_q, frame_valid_d;
   logic [15:0]           frame_len_q, frame_len_d;
   logic                  frame_error_q, frame_error_d;
   err_e                  err_code_q, err_code_d;
   logic                  overrun_q, overrun_d;
   logic                  busy_q;

   logic [7:0]            acc_sum;
   logic [15:0]           len_rx;
   logic [ADDR_WIDTH-1:0] idx_inc;
   logic                  is_sync;
   logic                  timeout_hit;

   assign acc_sum = acc_q + rx_data_i;
   assign len_rx  = {len_q[15:8], rx_data_i};
   assign idx_inc = idx_q + ADDR_WIDTH'(1);
   assign is_sync = rx_done_tick_i && (rx_data_i == SYNC_BYTE);

`ifdef FRAME_TIMEOUT_EN
   logic in_frame;
   logic timer_clr;
   logic timer_expired;

   assign in_frame  = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                      (state_q == ST_PAYLOAD) || (state_q == ST_CHECK);
   assign timer_clr = rx_done_tick_i || ((state_d == ST_LEN_HI) && (state_q != ST_LEN_HI));

   frame_timeout_timer #(
      .CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .clear_i   (timer_clr),
      .enable_i  (in_frame),
      .expired_o (timer_expired)
   );

   // A byte arriving on the expiry cycle still counts as in time.
   assign timeout_hit = in_frame && timer_expired && !rx_done_tick_i;
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_d       = state_q;
      len_d         = len_q;
      acc_d         = acc_q;
      idx_d         = idx_q;
      wr_en_d       = 1'b0;
      wr_addr_d     = wr_addr_q;
      wr_data_d     = wr_data_q;
      frame_valid_d = frame_valid_q;
      frame_len_d   = frame_len_q;
      frame_error_d = 1'b0;
      err_code_d    = err_code_q;
      overrun_d     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (is_sync) begin
               state_d = ST_LEN_HI;
            end
         end
         ST_LEN_HI: begin
            if (rx_done_tick_i) begin
               len_d   = {rx_data_i, 8'h00};
               acc_d   = rx_data_i;
               state_d = ST_LEN_LO;
            end
         end
         ST_LEN_LO: begin
            if (rx_done_tick_i) begin
               len_d = len_rx;
               acc_d = acc_sum;
               if (len_legal(len_rx, MAX_LEN)) begin
                  idx_d   = '0;
                  state_d = ST_PAYLOAD;
               end else begin
                  frame_error_d = 1'b1;
                  err_code_d    = ERR_LEN;
                  state_d       = ST_IDLE;
               end
            end
         end
         ST_PAYLOAD: begin
            if (rx_done_tick_i) begin
               wr_en_d   = 1'b1;
               wr_addr_d = idx_q;
               wr_data_d = rx_data_i;
               acc_d     = acc_sum;
               idx_d     = idx_inc;
               // len never exceeds MAX_PAYLOAD, so its low ADDR_WIDTH bits hold it exactly.
               if (idx_inc == len_q[ADDR_WIDTH-1:0]) begin
                  state_d = ST_CHECK;
               end
            end
         end
         ST_CHECK: begin
            if (rx_done_tick_i) begin
               if (acc_sum == 8'h00) begin
                  frame_valid_d = 1'b1;
                  frame_len_d   = len_q;
                  state_d       = ST_HOLD;
               end else begin
                  frame_error_d = 1'b1;
                  err_code_d    = ERR_CSUM;
                  state_d       = ST_IDLE;
               end
            end
         end
         ST_HOLD: begin
            if (frame_ack_i) begin
               frame_valid_d = 1'b0;
               state_d       = is_sync ? ST_LEN_HI : ST_IDLE;
            end else if (rx_done_tick_i) begin
               overrun_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (timeout_hit) begin
         frame_error_d = 1'b1;
         err_code_d    = ERR_TIMEOUT;
         state_d       = ST_IDLE;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q       <= ST_IDLE;
         len_q         <= '0;
         acc_q         <= '0;
         idx_q         <= '0;
         wr_en_q       <= 1'b0;
         wr_addr_q     <= '0;
         wr_data_q     <= '0;
         frame_valid_q <= 1'b0;
         frame_len_q   <= '0;
         frame_error_q <= 1'b0;
         err_code_q    <= ERR_NONE;
         overrun_q     <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         len_q         <= len_d;
         acc_q         <= acc_d;
         idx_q         <= idx_d;
         wr_en_q       <= wr_en_d;
         wr_addr_q     <= wr_addr_d;
         wr_data_q     <= wr_data_d;
         frame_valid_q <= frame_valid_d;
         frame_len_q   <= frame_len_d;
         frame_error_q <= frame_error_d;
         err_code_q    <= err_code_d;
         overrun_q     <= overrun_d;
         busy_q        <= (state_d != ST_IDLE);
      end
   end

   assign wr_en_o       = wr_en_q;
   assign wr_addr_o     = wr_addr_q;
   assign wr_data_o     = wr_data_q;
   assign frame_valid_o = frame_valid_q;
   assign frame_len_o   = frame_len_q;
   assign frame_error_o = frame_error_q;
   assign err_code_o    = err_code_q;
   assign overrun_o     = overrun_q;
   assign busy_o        = busy_q;

endmodule
